// File: rtl/nexys_starship_ssd_pkg.sv
// rtl/nexys_starship_ssd_pkg.sv - cathode constants, hex decoder and width helper for the SSD scanner
package nexys_starship_ssd_pkg;

    // {a,b,c,d,e,f,g,dp}, active low, decimal point off
    localparam logic [7:0] SEG_0     = 8'b0000001_1;
    localparam logic [7:0] SEG_1     = 8'b1001111_1;
    localparam logic [7:0] SEG_2     = 8'b0010010_1;
    localparam logic [7:0] SEG_3     = 8'b0000110_1;
    localparam logic [7:0] SEG_4     = 8'b1001100_1;
    localparam logic [7:0] SEG_5     = 8'b0100100_1;
    localparam logic [7:0] SEG_6     = 8'b0100000_1;
    localparam logic [7:0] SEG_7     = 8'b0001111_1;
    localparam logic [7:0] SEG_8     = 8'b0000000_1;
    localparam logic [7:0] SEG_9     = 8'b0000100_1;
    localparam logic [7:0] SEG_A     = 8'b0001000_1;
    localparam logic [7:0] SEG_B     = 8'b1100000_1;
    localparam logic [7:0] SEG_C     = 8'b0110001_1;
    localparam logic [7:0] SEG_D     = 8'b1000010_1;
    localparam logic [7:0] SEG_E     = 8'b0110000_1;
    localparam logic [7:0] SEG_F     = 8'b0111000_1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s[7:1];
    endfunction

    // Never narrower than one bit so a single-digit build still has a scan_idx port
    function automatic int CLOG2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/nexys_starship_hex2seg.sv
// rtl/nexys_starship_hex2seg.sv - combinational hex nibble to abcdefg segment decoder
module nexys_starship_hex2seg
    import nexys_starship_ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb seg = hex2seg(nibble);

endmodule

// File: rtl/nexys_starship_ssd_scanner.sv
// rtl/nexys_starship_ssd_scanner.sv - N-digit double-buffered seven-segment scanner; optional SSD_BLINK_EN
module nexys_starship_ssd_scanner
    import nexys_starship_ssd_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 14,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 26,
    localparam int IDX_W       = CLOG2(N_DIGITS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   An,
    output logic [7:0]            Cathodes,
    output logic [IDX_W-1:0]      scan_idx,
    output logic                  frame_tick
);

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [SCAN_DIV-1:0] BLANK_L  = SCAN_DIV'(BLANK_CYCLES);

    logic [SCAN_DIV-1:0]   presc, blank_cnt, blank_nx;
    logic [IDX_W-1:0]      idx_nx;
    logic                  tick, wrap, blink_off;
    logic [4*N_DIGITS-1:0] pend_dig, act_dig, act_dig_nx;
    logic [N_DIGITS-1:0]   pend_dp, pend_en, pend_blk;
    logic [N_DIGITS-1:0]   act_dp, act_en, act_blk;
    logic [N_DIGITS-1:0]   act_dp_nx, act_en_nx, act_blk_nx, an_nx;
    logic [3:0]            nib_nx;
    logic [6:0]            seg_nx;

    assign tick = &presc;
    assign wrap = tick && (scan_idx == LAST_IDX);

    always_comb begin
        idx_nx   = scan_idx;
        blank_nx = blank_cnt;
        if (tick) begin
            idx_nx   = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            blank_nx = '0;
        end else if (blank_cnt != BLANK_L) begin
            blank_nx = blank_cnt + 1'b1;
        end
    end

    // A load landing on the wrap tick bypasses pending so it shows in the frame that starts now
    always_comb begin
        {act_dig_nx, act_dp_nx, act_en_nx, act_blk_nx} = {act_dig, act_dp, act_en, act_blk};
        if (wrap) begin
            if (load)
                {act_dig_nx, act_dp_nx, act_en_nx, act_blk_nx} = {digits_in, dp_in, digit_en, blink_mask};
            else
                {act_dig_nx, act_dp_nx, act_en_nx, act_blk_nx} = {pend_dig, pend_dp, pend_en, pend_blk};
        end
    end

`ifdef SSD_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt, blink_nx;

    assign blink_nx  = blink_cnt + 1'b1;
    assign blink_off = blink_nx[BLINK_DIV-1] & act_blk_nx[idx_nx];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) blink_cnt <= '0;
        else        blink_cnt <= blink_nx;
    end
`else
    logic unused_blink;

    assign blink_off    = 1'b0;
    assign unused_blink = ^{act_blk_nx, BLINK_DIV > 0};
`endif

    assign nib_nx = act_dig_nx[{idx_nx, 2'b00} +: 4];

    nexys_starship_hex2seg u_hex2seg (
        .nibble (nib_nx),
        .seg    (seg_nx)
    );

    always_comb begin
        an_nx = '1;
        if (blank_nx >= BLANK_L && act_en_nx[idx_nx] && !blink_off)
            an_nx[idx_nx] = 1'b0;
    end

    // Outputs are computed from next-state values so they change on the same edge as scan_idx
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc      <= '0;
            blank_cnt  <= '0;
            scan_idx   <= '0;
            frame_tick <= 1'b0;
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_blk   <= '0;
            act_dig    <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            act_blk    <= '0;
            An         <= '1;
            Cathodes   <= SEG_BLANK;
        end else begin
            presc      <= presc + 1'b1;
            blank_cnt  <= blank_nx;
            scan_idx   <= idx_nx;
            frame_tick <= wrap;
            if (load) begin
                pend_dig <= digits_in;
                pend_dp  <= dp_in;
                pend_en  <= digit_en;
                pend_blk <= blink_mask;
            end
            act_dig    <= act_dig_nx;
            act_dp     <= act_dp_nx;
            act_en     <= act_en_nx;
            act_blk    <= act_blk_nx;
            An         <= an_nx;
            Cathodes   <= {seg_nx, ~act_dp_nx[idx_nx]};
        end
    end

endmodule

// File: tb/tb_nexys_starship_ssd_scanner.sv
// tb/tb_nexys_starship_ssd_scanner.sv - scoreboard bench for the SSD scanner; honours SSD_BLINK_EN
module tb_nexys_starship_ssd_scanner;

    localparam int N     = 8;
    localparam int SD    = 4;
    localparam int BL    = 2;
    localparam int BD    = 6;
    localparam int SLOT  = 1 << SD;
    localparam int FRAME = N * SLOT;

    logic           clk = 1'b0;
    logic           Reset;
    logic           load = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   dp_in = '0, digit_en = '0, blink_mask = '0;
    logic [N-1:0]   An;
    logic [7:0]     Cathodes;
    logic [2:0]     scan_idx;
    logic           frame_tick;

    nexys_starship_ssd_scanner #(
        .N_DIGITS     (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL),
        .BLINK_DIV    (BD)
    ) dut (
        .Clk        (clk),
        .Reset      (Reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .load       (load),
        .An         (An),
        .Cathodes   (Cathodes),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] an;
        logic [7:0]   cath;
        logic [2:0]   idx;
        logic         ft;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           e_m, e_c;
    int             k = 0, n_checks = 0, n_pass = 0;
    int             idx_m, pos_m;
    logic           blink_hit;
    logic [6:0]     seg_tab [16];
    logic [4*N-1:0] last_dig, act_dig;
    logic [N-1:0]   last_dp, last_en, last_blk, act_dp, act_en, act_blk;

    initial begin
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100; seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, got, want);
    endtask

    // Reference: k edges after reset release, the display sits in slot k/SLOT, SLOT-phase k%SLOT,
    // and shows whatever was last loaded at or before the most recent frame boundary.
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            k = 0;
            {last_dig, last_dp, last_en, last_blk} = '0;
            {act_dig, act_dp, act_en, act_blk} = '0;
            exp_q.delete();
        end else begin
            k++;
            if (load) {last_dig, last_dp, last_en, last_blk} = {digits_in, dp_in, digit_en, blink_mask};
            if (k % FRAME == 0) {act_dig, act_dp, act_en, act_blk} = {last_dig, last_dp, last_en, last_blk};
            idx_m = (k / SLOT) % N;
            pos_m = k % SLOT;
`ifdef SSD_BLINK_EN
            blink_hit = ((k % (1 << BD)) >= (1 << (BD - 1))) && act_blk[idx_m];
`else
            blink_hit = 1'b0;
`endif
            e_m.idx = idx_m[2:0];
            e_m.ft  = (k % FRAME == 0);
            e_m.an  = '1;
            if (pos_m >= BL && act_en[idx_m] && !blink_hit) e_m.an[idx_m] = 1'b0;
            e_m.cath = {seg_tab[act_dig[4*idx_m +: 4]], ~act_dp[idx_m]};
            exp_q.push_back(e_m);
        end
    end

    always @(negedge clk) begin
        if (Reset && k > 0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow at edge %0d: got 0 entries expected 1", k);
            end else begin
                e_c = exp_q.pop_front();
                chk("an", 32'(An), 32'(e_c.an));
                chk("cathodes", 32'(Cathodes), 32'(e_c.cath));
                chk("scan_idx", 32'(scan_idx), 32'(e_c.idx));
                chk("frame_tick", 32'(frame_tick), 32'(e_c.ft));
            end
        end
    end

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en, input logic [7:0] bm);
        @(negedge clk);
        load = 1'b1; digits_in = d; dp_in = dp; digit_en = en; blink_mask = bm;
        @(negedge clk);
        load = 1'b0;
        digits_in = $urandom; dp_in = 8'($urandom); digit_en = 8'($urandom); blink_mask = 8'($urandom);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i <= FRAME && (k % FRAME) != ph; i++) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"}, 32'(An), 32'hFF);
        chk({tag, "_cathodes"}, 32'(Cathodes), 32'hFF);
        chk({tag, "_scan_idx"}, 32'(scan_idx), 32'h0);
        chk({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        Reset = 1'b1;
        #1 Reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        Reset = 1'b1;

        do_load(32'h01234567, 8'h00, 8'hFF, 8'h00);
        repeat (2 * FRAME) @(negedge clk);

        wait_phase(38);
        do_load($urandom, 8'h08, 8'hF7, 8'h02);
        repeat (2 * FRAME) @(negedge clk);

        wait_phase(FRAME - 2);
        do_load($urandom, 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (FRAME) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 150)) @(negedge clk);
            do_load($urandom, 8'($urandom), 8'($urandom | 32'h1), 8'($urandom));
        end
        repeat (FRAME) @(negedge clk);

        wait_phase(FRAME / 2 + 5);
        @(posedge clk);
        #3 Reset = 1'b0;
        #1 chk_reset("midreset");
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        do_load($urandom, 8'($urandom), 8'hFF, 8'hFF);
        repeat (2 * FRAME + 20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
